// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: hardware return-address stack (LIFO) for the CPU.
// Call and return strobes push or pop PCs. The top of stack drives the PC mux
// combinationally. Full/empty are decoded from the stack pointer. Misuse raises
// sticky overflow/underflow flags.
module call_stack_ctrl #(
  parameter int DW    = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,      // asynchronous, active-low
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  input  logic          clr_err,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  // Return-address storage. It has no reset, and entries above sp are simply ignored.
  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   sp_reg, sp_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] top_addr;
  logic          ov_set, un_set;

  // When sp == DEPTH, the low AW bits are zero.
  // Subtracting one wraps to DEPTH-1, which is the correct top entry.
  assign top_addr = sp_reg[AW-1:0] - AW'(1);

  // Status and top-of-stack decode. This is purely combinational from sp and the array.
  always_comb begin
    empty = (sp_reg == '0);
    full  = (sp_reg == SP_FULL);
    dout  = empty ? '0 : mem[top_addr];
  end

  assign count     = sp_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // Decode {push,pop} into a pointer update, an array write and error events.
  always_comb begin
    sp_next = sp_reg;
    wr_en   = 1'b0;
    wr_addr = sp_reg[AW-1:0];
    ov_set  = 1'b0;
    un_set  = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          sp_next = sp_reg + SP_ONE;
        end else begin
          ov_set = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) sp_next = sp_reg - SP_ONE;
        else        un_set  = 1'b1;
      end
      2'b11: begin
        // A simultaneous call and return replaces the top entry in place.
        if (!empty) begin
          wr_en   = 1'b1;
          wr_addr = top_addr;
        end else begin
          un_set = 1'b1;
        end
      end
      default: ;
    endcase
    // A new error wins over a same-cycle clear.
    overflow_next  = ov_set | (overflow_reg  & ~clr_err);
    underflow_next = un_set | (underflow_reg & ~clr_err);
  end

  // Pointer and sticky error flags. Reset discards all entries immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Per-entry write enables. The array contents are deliberately left unreset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == AW'(gi))) mem[gi] <= din;
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed testbench for call_stack_ctrl: push/pop ordering, full/empty limits,
// sticky error flags with clear priority, top replacement and asynchronous reset.
module tb_call_stack_ctrl;

  localparam int DW = 10, DEPTH = 16, AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop, clr_err;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic          empty, full, overflow, underflow;

  int tests = 0;
  int fails = 0;

  call_stack_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();

    // 1. Reset then idle
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // 2. Push three values, then pop them in reverse order
    push = 1'b1;
    din = 10'h005; tick();
    din = 10'h0A0; tick();
    din = 10'h3FF; tick();
    push = 1'b0;
    chk("p3_count", count, 3);
    chk("p3_dout", dout, 10'h3FF);
    pop = 1'b1;
    chk("pop1_dout", dout, 10'h3FF); tick();
    chk("pop2_dout", dout, 10'h0A0); tick();
    chk("pop3_dout", dout, 10'h005); tick();
    pop = 1'b0;
    chk("pop_empty", empty, 1);
    chk("pop_dout0", dout, 0);
    chk("pop_count0", count, 0);
    chk("pop_unf", underflow, 0);

    // 3. Fill the stack, push once more while full, then clear the error
    push = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      din = DW'(i);
      tick();
    end
    push = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    chk("fill_dout", dout, 15);
    chk("fill_count", count, 16);
    push = 1'b1; din = 10'h2AA; tick(); push = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_dout", dout, 15);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_clr", overflow, 0);

    // 5b. Replace the top entry while full: no overflow, count unchanged
    push = 1'b1; pop = 1'b1; din = 10'h155; tick();
    push = 1'b0; pop = 1'b0;
    chk("rep_full_count", count, 16);
    chk("rep_full_dout", dout, 10'h155);
    chk("rep_full_ovf", overflow, 0);
    // Drain the stack. The replaced top comes out first, then 14 down to 0.
    pop = 1'b1;
    chk("drain_top", dout, 10'h155); tick();
    for (int i = 14; i >= 0; i--) begin
      chk($sformatf("drain_%0d", i), dout, i);
      tick();
    end
    pop = 1'b0;
    chk("drain_empty", empty, 1);

    // 4. Underflow, then set-wins-over-clear
    pop = 1'b1; tick();
    chk("unf_set", underflow, 1);
    chk("unf_count", count, 0);
    clr_err = 1'b1; tick();
    chk("unf_setwins", underflow, 1);
    pop = 1'b0; tick(); clr_err = 1'b0;
    chk("unf_clr", underflow, 0);
    // Push and pop together on an empty stack also counts as an underflow.
    push = 1'b1; pop = 1'b1; din = 10'h333; tick();
    push = 1'b0; pop = 1'b0;
    chk("pp_empty_unf", underflow, 1);
    chk("pp_empty_count", count, 0);
    chk("pp_empty_dout", dout, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // 5. Replace the top entry with one item on the stack
    push = 1'b1; din = 10'h011; tick();
    pop = 1'b1; din = 10'h022; tick();
    push = 1'b0; pop = 1'b0;
    chk("rep_count", count, 1);
    chk("rep_dout", dout, 10'h022);
    chk("rep_unf", underflow, 0);
    pop = 1'b1; tick(); pop = 1'b0;

    // 6. Asynchronous reset in the middle of a cycle
    push = 1'b1;
    din = 10'h100; tick();
    din = 10'h101; tick();
    push = 1'b0;
    chk("pre_rst_count", count, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dout", dout, 0);
    chk("arst_empty", empty, 1);
    #1 reset = 1'b1;
    push = 1'b1; din = 10'h007; tick(); push = 1'b0;
    chk("post_rst_count", count, 1);
    chk("post_rst_dout", dout, 10'h007);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
